// File: rtl/fetch_if.sv
// Instruction-memory read port shared by the fetch unit (master) and memory (slave).
interface fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch: request a word, hold it until the datapath retires it,
// then steer pc by jr/jump/branch. A misaligned target halts until reset.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   fetch_if.master     imem,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc_plus4,
   input  logic        stall,
   input  logic        branch,
   input  logic        jump,
   input  logic        jal,
   input  logic        jr,
   input  logic        zero,
   input  logic [31:0] rs_data,
   output logic        addr_err,
   output logic [31:0] retired_cnt
);

   typedef enum logic [1:0] {
      StReq   = 2'd0,
      StValid = 2'd1,
      StHalt  = 2'd2
   } state_e;

   state_e      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_req;
   logic        r_valid;
   logic        r_addr_err;
   logic [31:0] r_retired_cnt;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_br_offset;
   logic [31:0] w_next_pc;
   logic        w_misaligned;

   assign w_pc_plus4  = r_pc + 32'd4;
   assign w_br_offset = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

   always_comb begin
      w_next_pc = w_pc_plus4;
      if (jr) begin
         w_next_pc = rs_data;
      end else if (jump || jal) begin
         w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
      end else if (branch && zero) begin
         w_next_pc = w_pc_plus4 + w_br_offset;
      end
   end

   assign w_misaligned = (w_next_pc[1:0] != 2'b00);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= StReq;
         r_pc          <= RESET_PC;
         r_instr       <= 32'd0;
         r_req         <= 1'b1;
         r_valid       <= 1'b0;
         r_addr_err    <= 1'b0;
         r_retired_cnt <= 32'd0;
      end else begin
         case (r_state)
            StReq: begin
               if (imem.imem_ack) begin
                  r_instr <= imem.imem_rdata;
                  r_state <= StValid;
                  r_req   <= 1'b0;
                  r_valid <= 1'b1;
               end
            end
            StValid: begin
               if (!stall) begin
                  r_retired_cnt <= r_retired_cnt + 32'd1;
                  r_valid       <= 1'b0;
                  // A bad target is still a retire, but pc keeps the faulting instruction's address.
                  if (w_misaligned) begin
                     r_state    <= StHalt;
                     r_addr_err <= 1'b1;
                     r_req      <= 1'b0;
                  end else begin
                     r_pc    <= w_next_pc;
                     r_state <= StReq;
                     r_req   <= 1'b1;
                  end
               end
            end
            StHalt: begin
               r_req      <= 1'b0;
               r_valid    <= 1'b0;
               r_addr_err <= 1'b1;
            end
            default: begin
               r_state    <= StHalt;
               r_req      <= 1'b0;
               r_valid    <= 1'b0;
               r_addr_err <= 1'b1;
            end
         endcase
      end
   end

   assign imem.imem_req  = r_req;
   assign imem.imem_addr = r_pc;
   assign instr          = r_instr;
   assign instr_valid    = r_valid;
   assign pc_plus4       = w_pc_plus4;
   assign addr_err       = r_addr_err;
   assign retired_cnt    = r_retired_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected fetch addresses are queued as stimulus is chosen
// and popped when the DUT raises a request.
module tb_fetch_unit;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fetch_if bus ();
   fetch_if bus2 ();

   logic        stall, branch, jump, jal, jr, zero;
   logic [31:0] rs_data;

   logic [31:0] instr, pc_plus4, retired_cnt;
   logic        instr_valid, addr_err;
   logic [31:0] instr2, pc_plus4_2, retired_cnt2;
   logic        instr_valid2, addr_err2;

   fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .imem        (bus),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc_plus4    (pc_plus4),
      .stall       (stall),
      .branch      (branch),
      .jump        (jump),
      .jal         (jal),
      .jr          (jr),
      .zero        (zero),
      .rs_data     (rs_data),
      .addr_err    (addr_err),
      .retired_cnt (retired_cnt)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .clk         (clk),
      .rst         (rst),
      .imem        (bus2),
      .instr       (instr2),
      .instr_valid (instr_valid2),
      .pc_plus4    (pc_plus4_2),
      .stall       (stall),
      .branch      (branch),
      .jump        (jump),
      .jal         (jal),
      .jr          (jr),
      .zero        (zero),
      .rs_data     (rs_data),
      .addr_err    (addr_err2),
      .retired_cnt (retired_cnt2)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctrl();
      stall  = 1'b0;
      branch = 1'b0;
      jump   = 1'b0;
      jal    = 1'b0;
      jr     = 1'b0;
      zero   = 1'b0;
   endtask

   task automatic do_fetch(input logic [31:0] word);
      logic [31:0] ea;
      for (int i = 0; i < 20 && bus.imem_req !== 1'b1; i++) step();
      check("req_seen", {31'd0, bus.imem_req}, 32'd1);
      ea = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      check("imem_addr", bus.imem_addr, ea);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = word;
      step();
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'hDEAD_BEEF;
      check("instr_valid", {31'd0, instr_valid}, 32'd1);
      check("instr", instr, word);
      check("req_low_valid", {31'd0, bus.imem_req}, 32'd0);
   endtask

   // Caller sets control inputs; this performs one unstalled VALID cycle.
   task automatic retire();
      stall = 1'b0;
      step();
      exp_cnt = exp_cnt + 32'd1;
      clear_ctrl();
      check("retired_cnt", retired_cnt, exp_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_ctrl();
      rs_data         = 32'd0;
      bus.imem_ack    = 1'b1;
      bus.imem_rdata  = 32'hCAFE_F00D;
      bus2.imem_ack   = 1'b0;
      bus2.imem_rdata = 32'd0;
      exp_cnt         = 32'd0;

      // Reset with an ack asserted: must be ignored.
      rst = 1'b0;
      repeat (3) step();
      check("rst_req", {31'd0, bus.imem_req}, 32'd1);
      check("rst_addr", bus.imem_addr, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_err", {31'd0, addr_err}, 32'd0);
      check("rst_cnt", retired_cnt, 32'd0);
      bus.imem_ack = 1'b0;
      rst = 1'b1;
      step();
      check("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
      check("post_rst_instr", instr, 32'd0);

      // Sequential fetches at zero-wait latency.
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      for (int i = 0; i < 3; i++) begin
         do_fetch(32'h0);
         retire();
      end
      check("seq_cnt3", retired_cnt, 32'd3);
      check("seq_next_addr", bus.imem_addr, 32'hC);

      // Stall holds everything; acks and control inputs are ignored meanwhile.
      exp_q.push_back(32'hC);
      do_fetch(32'h1234_5678);
      stall          = 1'b1;
      jr             = 1'b1;
      rs_data        = 32'h100;
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'h5555_AAAA;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_instr", instr, 32'h1234_5678);
         check("stall_addr", bus.imem_addr, 32'hC);
         check("stall_req", {31'd0, bus.imem_req}, 32'd0);
         check("stall_valid", {31'd0, instr_valid}, 32'd1);
         check("stall_cnt", retired_cnt, exp_cnt);
      end
      bus.imem_ack = 1'b0;
      jr           = 1'b0;
      retire();

      // Taken branch, untaken branch, then jr priority over jump/branch.
      exp_q.push_back(32'h10);
      do_fetch(32'h1000_0003);
      check("br_pc_plus4", pc_plus4, 32'h14);
      branch = 1'b1;
      zero   = 1'b1;
      retire();
      exp_q.push_back(32'h20);
      do_fetch(32'h1000_0003);
      branch = 1'b1;
      zero   = 1'b0;
      retire();
      exp_q.push_back(32'h24);
      do_fetch(32'h0800_0001);
      jr      = 1'b1;
      jump    = 1'b1;
      branch  = 1'b1;
      zero    = 1'b1;
      rs_data = 32'h10;
      retire();
      exp_q.push_back(32'h10);
      do_fetch(32'h1000_0003);
      branch = 1'b1;
      zero   = 1'b0;
      retire();

      // JAL from the upper region.
      exp_q.push_back(32'h14);
      do_fetch(32'h0);
      jr      = 1'b1;
      rs_data = 32'h4000_0000;
      retire();
      exp_q.push_back(32'h4000_0000);
      do_fetch(32'h0800_0010);
      check("jal_pc_plus4", pc_plus4, 32'h4000_0004);
      jal = 1'b1;
      retire();
      exp_q.push_back(32'h4000_0040);
      do_fetch(32'h0800_0003);
      jump = 1'b1;
      retire();
      exp_q.push_back(32'h4000_000C);
      do_fetch(32'h0);

      // Misaligned jr target halts; retire still counts, pc unchanged.
      jr      = 1'b1;
      rs_data = 32'h0000_0102;
      retire();
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hFFFF_0000;
      for (int i = 0; i < 10; i++) begin
         stall = i[0];
         step();
         check("halt_err", {31'd0, addr_err}, 32'd1);
         check("halt_req", {31'd0, bus.imem_req}, 32'd0);
         check("halt_valid", {31'd0, instr_valid}, 32'd0);
         check("halt_addr", bus.imem_addr, 32'h4000_000C);
         check("halt_instr", instr, 32'h0);
      end
      bus.imem_ack = 1'b0;
      clear_ctrl();

      // Asynchronous reset mid-cycle.
      #2;
      rst = 1'b0;
      #1;
      check("arst_err", {31'd0, addr_err}, 32'd0);
      check("arst_addr", bus.imem_addr, 32'd0);
      check("arst_req", {31'd0, bus.imem_req}, 32'd1);
      check("arst_cnt", retired_cnt, 32'd0);
      step();
      rst     = 1'b1;
      exp_cnt = 32'd0;
      exp_q.push_back(32'h0);
      do_fetch(32'h0000_ABCD);
      retire();

      // Reset while a request is pending, ack arriving during reset.
      check("pend_addr", bus.imem_addr, 32'h4);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'h0000_0077;
      rst = 1'b0;
      step();
      check("pend_instr", instr, 32'd0);
      check("pend_valid", {31'd0, instr_valid}, 32'd0);
      bus.imem_ack = 1'b0;
      rst = 1'b1;

      // Wrapping RESET_PC instance: one sequential retire lands at 0.
      check("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
      check("wrap_req0", {31'd0, bus2.imem_req}, 32'd1);
      bus2.imem_ack   = 1'b1;
      bus2.imem_rdata = 32'h0;
      step();
      bus2.imem_ack = 1'b0;
      check("wrap_valid", {31'd0, instr_valid2}, 32'd1);
      check("wrap_pc_plus4", pc_plus4_2, 32'h0);
      step();
      check("wrap_addr1", bus2.imem_addr, 32'h0);
      check("wrap_cnt", retired_cnt2, 32'd1);
      check("wrap_req1", {31'd0, bus2.imem_req}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset; bits [1:0] SHALL be 0.
REQ-002 clk  in  1  single clock; all state changes occur on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 imem_req  out  1  instruction-memory read request.
REQ-005 imem_addr  out  32  byte address of the requested word, equal to pc.
REQ-006 imem_ack  in  1  read data valid on imem_rdata this cycle.
REQ-007 imem_rdata  in  32  instruction word from memory.
REQ-008 instr  out  32  held instruction; [31:26] drives the main decoder opcode.
REQ-009 instr_valid  out  1  instr holds a fetched, not-yet-retired instruction.
REQ-010 pc_plus4  out  32  pc + 4, used as the JAL link value.
REQ-011 stall  in  1  datapath not ready to retire the held instruction.
REQ-012 branch, jump, jal, jr, zero  in  1 each  decoded control signals and the ALU zero flag for the held instruction.
REQ-013 rs_data  in  32  register rs value, the JR target.
REQ-014 addr_err  out  1  sticky misaligned-target flag.
REQ-015 retired_cnt  out  32  count of retired instructions.

Function
REQ-016 FSM states SHALL be REQ (fetch pending), VALID (instruction held) and HALT (error).
REQ-017 In REQ: imem_req=1 and instr_valid=0. On imem_ack, instr SHALL capture imem_rdata, and the FSM SHALL move to VALID on the next edge.
REQ-018 Requests SHALL have zero-wait minimum latency: ack in the same cycle as req gives instr_valid=1 in the following cycle.
REQ-019 In VALID: imem_req=0, instr_valid=1, and instr SHALL be held stable.
REQ-020 VALID with stall=1 SHALL hold pc, instr and state.
REQ-021 VALID with stall=0 retires the held instruction: pc<=next_pc, retired_cnt+1, then REQ. Minimum throughput is 1 instruction per 2 cycles.
REQ-022 next_pc priority, highest first:
- jr: rs_data
- jump or jal: {pc_plus4[31:28], instr[25:0], 2'b00}
- branch and zero: pc_plus4 + (sign-extended instr[15:0] << 2)
- otherwise: pc_plus4
REQ-023 All address arithmetic SHALL be 32-bit modulo 2^32; pc=32'hFFFF_FFFC with a sequential retire SHALL wrap pc to 0.
REQ-024 branch=1 with zero=0 SHALL take the sequential path.
REQ-025 A retire whose next_pc[1:0]!=0 SHALL move to HALT.
- pc SHALL be left unchanged.
- addr_err SHALL be set to 1.
- retired_cnt SHALL still increment.
REQ-026 In HALT: imem_req=0 and instr_valid=0 until reset; addr_err SHALL stay 1.
REQ-027 imem_ack outside REQ SHALL be ignored and SHALL NOT change instr.
REQ-028 retired_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-029 stall SHALL have no effect in REQ or HALT.

Reset
REQ-030 Reset asserted asynchronously SHALL force:
- pc=RESET_PC, state=REQ, instr=0, instr_valid=0
- addr_err=0, retired_cnt=0
REQ-031 imem_req SHALL be 1 in the first cycle after reset release.
REQ-032 Reset during a pending request SHALL abandon that request; an ack arriving during reset SHALL be ignored.

Verification
REQ-033 Reset release, imem_ack=1 every REQ cycle, no control signals -> imem_addr sequence 0,4,8; retired_cnt=3 after 6 cycles.
REQ-034 Held instr 0x1000_0003, branch=1, zero=1, pc=0x10 -> next imem_addr=0x20. Same case with zero=0 -> 0x14.
REQ-035 pc=0x4000_0000, instr=0x0800_0010, jal=1 -> pc_plus4=0x4000_0004 during VALID; next imem_addr=0x4000_0040.
REQ-036 stall=1 for 5 cycles in VALID -> instr and pc stable, imem_req=0, retired_cnt unchanged; retires on the first stall=0 cycle.
REQ-037 jr=1, rs_data=0x0000_0102 -> HALT, addr_err=1, imem_req=0 held for 10 cycles; rst pulse -> addr_err=0, imem_addr=RESET_PC.
REQ-038 RESET_PC=32'hFFFF_FFFC, one sequential retire -> imem_addr=0.
